shift_counter_param: RTL

//  Parametrised shift-register counter: ring (one-hot) or Johnson (twisted-ring) sequence.

---
 rtl/shift_cnt_pkg.sv | 25 ++
 rtl/shift_counter_param_legal_chk.sv | 14 +
 rtl/shift_counter_param.sv | 75 +++++++
 3 files changed

// File: rtl/shift_cnt_pkg.sv
// Shared mode encodings and the legality rule for ring / Johnson shift counters.
package shift_cnt_pkg;

  localparam int MODE_RING       = 0;
  localparam int MODE_JOHNSON    = 1;
  localparam int SHIFT_CNT_MAX_W = 64;

  // Ring: exactly one bit set. Johnson: at most one transition between adjacent bits.
  function automatic logic shift_cnt_legal(input logic [SHIFT_CNT_MAX_W-1:0] value,
                                           input int width,
                                           input int mode);
    int ones;
    int trans;
    ones  = 0;
    trans = 0;
    for (int i = 0; i < SHIFT_CNT_MAX_W; i++) begin
      if (i < width && value[i]) ones++;
    end
    for (int i = 0; i < SHIFT_CNT_MAX_W - 1; i++) begin
      if (i < width - 1 && (value[i] != value[i+1])) trans++;
    end
    return (mode == MODE_RING) ? (ones == 1) : (trans <= 1);
  endfunction

endpackage

// File: rtl/shift_counter_param_legal_chk.sv
// Combinational legality checker for the counter state; no latency, no flow control.
module shift_cnt_legal_chk
  import shift_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_JOHNSON
) (
  input  logic [WIDTH-1:0] value,
  output logic             illegal
);

  assign illegal = ~shift_cnt_legal(SHIFT_CNT_MAX_W'(value), WIDTH, MODE);

endmodule

// File: rtl/shift_counter_param.sv
// Ring / Johnson shift counter with load, direction, wrap flag and illegal-state flag.
// Define SHIFT_CNT_SELFCORRECT_EN to jump illegal states back to RESET_VAL on the next enabled step.
module shift_counter_param
  import shift_cnt_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               MODE      = MODE_JOHNSON,
  parameter logic [WIDTH-1:0] RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             illegal
);

  if (WIDTH < 2 || WIDTH > SHIFT_CNT_MAX_W) begin : g_bad_width
    $error("shift_counter_param: WIDTH out of range");
  end
  if (!shift_cnt_legal(SHIFT_CNT_MAX_W'(RESET_VAL), WIDTH, MODE)) begin : g_bad_reset_val
    $error("shift_counter_param: RESET_VAL is not a legal state for MODE");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step;
  logic             fb;

  shift_cnt_legal_chk #(.WIDTH(WIDTH), .MODE(MODE)) u_legal_chk (
    .value   (q_q),
    .illegal (illegal)
  );

  // Johnson feeds back the inverted outgoing bit; ring feeds it back unchanged.
  always_comb begin
    fb   = dir ? q_q[0] : q_q[WIDTH-1];
    fb   = (MODE == MODE_JOHNSON) ? ~fb : fb;
    step = dir ? {fb, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fb};
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (reset) begin
      q_d = RESET_VAL;
    end else if (load) begin
      q_d = load_val;
    end else if (en) begin
`ifdef SHIFT_CNT_SELFCORRECT_EN
      if (illegal) begin
        q_d = RESET_VAL;
      end else begin
        q_d    = step;
        wrap_d = (step == RESET_VAL);
      end
`else
      q_d    = step;
      wrap_d = (step == RESET_VAL);
`endif
    end
  end

  always_ff @(posedge clk) begin
    q_q    <= q_d;
    wrap_q <= wrap_d;
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule
